// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered byte feeder that launches queued bytes into an idle UART Tx.
module uart_tx_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr_overflow,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = DEPTH[DEPTH_LOG2:0];
  localparam logic [7:0] ACK_T = ACK_TIMEOUT[7:0];
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [7:0] ack_cnt;
  logic push, pop, ack_wait, ack_expired;
  assign empty = level == '0;
  assign full  = level == DEPTH_L;
  // A pop never frees space for a same-cycle write: full is the registered view.
  assign push  = wr_valid && !full;
  always_comb begin
    pop         = state == IDLE && !empty && !tx_busy;
    ack_wait    = state == WAIT_ACK && !tx_busy;
    ack_expired = ack_wait && (ack_cnt + 8'd1) == ACK_T;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE     ? (pop ? WAIT_ACK : IDLE) :
               state == WAIT_ACK ? (tx_busy ? WAIT_DONE : ack_expired ? IDLE : WAIT_ACK) :
                                   (tx_busy ? WAIT_DONE : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      ack_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
      if (wr_valid && full) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      tx_start <= pop;
      if (pop) tx_data <= mem[rd_ptr];
      ack_cnt <= pop ? 8'd0 : ack_wait ? ack_cnt + 8'd1 : ack_cnt;
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed scenarios for the Tx feeder with a simple Tx busy model.
module tb_uart_tx_feeder;
  localparam int ACK_TIMEOUT = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic clr_overflow = 1'b0;
  logic busy_force = 1'b0;
  logic model_en = 1'b0;
  logic busy_model = 1'b0;
  logic tx_busy;
  logic tx_start;
  logic [7:0] tx_data;
  logic [4:0] level;
  logic empty, full, overflow;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int busy_len = 100;
  int busy_viol = 0;
  logic [7:0] got[$];
  int t_launch[$];

  assign tx_busy = model_en ? busy_model : busy_force;

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .clr_overflow(clr_overflow), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .level(level), .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Launch logger and Tx model: busy for busy_len cycles after each tx_start.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (tx_start) begin
        got.push_back(tx_data);
        t_launch.push_back(cyc);
        if (tx_busy) busy_viol++;
      end
      if (tx_start && model_en) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      busy_model = busy_cnt > 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launches(input int n, input int bound);
    for (int k = 0; k < bound && got.size() < n; k++) step();
    checks++;
    if (got.size() != n) begin
      failures++;
      $display("FAIL launch_count got=%0d want=%0d", got.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_level level=%0d empty=%b full=%b want 0/1/0", level, empty, full);
    end
    checks++;
    if (overflow !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_out ovf=%b start=%b data=%h want 0/0/00", overflow, tx_start, tx_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    model_en = 1'b0;
    busy_force = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    checks++;
    if (tx_start !== 1'b0 || level !== 5'd1) begin
      failures++;
      $display("FAIL single_queued start=%b level=%0d want 0/1", tx_start, level);
    end
    step();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5 || level !== 5'd0) begin
      failures++;
      $display("FAIL single_launch start=%b data=%h level=%0d want 1/a5/0", tx_start, tx_data, level);
    end
    step();
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_pulse start=%b data=%h want 0/a5", tx_start, tx_data);
    end
    repeat (20) step();
  endtask

  task automatic test_burst();
    got.delete();
    t_launch.delete();
    busy_viol = 0;
    busy_len = 100;
    model_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(i);
      step();
    end
    wr_valid = 1'b0;
    wait_launches(5, 1000);
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(i + 1)) begin
        failures++;
        $display("FAIL burst_order idx=%0d got=%h want=%h", i, got[i], 8'(i + 1));
      end
    end
    for (int i = 1; i < t_launch.size(); i++) begin
      checks++;
      if (t_launch[i] - t_launch[i-1] != 102) begin
        failures++;
        $display("FAIL burst_interval idx=%0d got=%0d want=102", i, t_launch[i] - t_launch[i-1]);
      end
    end
    checks++;
    if (busy_viol != 0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL burst_clean busy_viol=%0d ovf=%b want 0/0", busy_viol, overflow);
    end
    repeat (110) step();
  endtask

  task automatic test_overflow();
    model_en = 1'b0;
    busy_force = 1'b1;
    got.delete();
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'h10 + 8'(i);
      step();
      if (i == 14) begin
        checks++;
        if (full !== 1'b0 || level !== 5'd15) begin
          failures++;
          $display("FAIL ovf_15 full=%b level=%0d want 0/15", full, level);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_16 full=%b level=%0d ovf=%b want 1/16/0", full, level, overflow);
    end
    wr_data = 8'hEE;
    step();
    wr_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drop ovf=%b level=%0d full=%b want 1/16/1", overflow, level, full);
    end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear ovf=%b want 0", overflow);
    end
    wr_valid = 1'b1;
    wr_data = 8'hDD;
    clr_overflow = 1'b1;
    step();
    wr_valid = 1'b0;
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      failures++;
      $display("FAIL ovf_drop_wins ovf=%b level=%0d want 1/16", overflow, level);
    end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    busy_len = 20;
    model_en = 1'b1;
    busy_force = 1'b0;
    wait_launches(16, 1000);
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'h10 + 8'(i)) begin
        failures++;
        $display("FAIL ovf_drain idx=%0d got=%h want=%h", i, got[i], 8'h10 + 8'(i));
      end
    end
    repeat (30) step();
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_after empty=%b ovf=%b want 1/0", empty, overflow);
    end
  endtask

  task automatic test_wrap();
    int i;
    got.delete();
    busy_len = 30;
    model_en = 1'b1;
    i = 0;
    for (int k = 0; k < 3000 && i < 40; k++) begin
      if (!full) begin
        wr_valid = 1'b1;
        wr_data = 8'h40 + 8'(i);
        i++;
      end else wr_valid = 1'b0;
      step();
    end
    wr_valid = 1'b0;
    wait_launches(40, 3000);
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== 8'h40 + 8'(k)) begin
        failures++;
        $display("FAIL wrap_seq idx=%0d got=%h want=%h", k, got[k], 8'h40 + 8'(k));
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL wrap_ovf ovf=%b want 0", overflow);
    end
    repeat (40) step();
  endtask

  task automatic test_timeout();
    model_en = 1'b0;
    busy_force = 1'b0;
    repeat (5) step();
    got.delete();
    t_launch.delete();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'h71 + 8'(i);
      step();
    end
    wr_valid = 1'b0;
    wait_launches(3, 200);
    repeat (40) step();
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL timeout_relaunch launches=%0d want=3", got.size());
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      checks++;
      if (got[i] !== 8'h71 + 8'(i)) begin
        failures++;
        $display("FAIL timeout_order idx=%0d got=%h want=%h", i, got[i], 8'h71 + 8'(i));
      end
    end
    for (int i = 1; i < t_launch.size() && i < 3; i++) begin
      checks++;
      if (t_launch[i] - t_launch[i-1] != ACK_TIMEOUT + 1) begin
        failures++;
        $display("FAIL timeout_interval idx=%0d got=%0d want=%0d", i, t_launch[i] - t_launch[i-1], ACK_TIMEOUT + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    busy_len = 50;
    busy_viol = 0;
    model_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'h81 + 8'(i);
      step();
    end
    wr_valid = 1'b0;
    repeat (10) step();
    checks++;
    if (level !== 5'd3 || tx_data !== 8'h81) begin
      failures++;
      $display("FAIL mid_pre level=%0d data=%h want 3/81", level, tx_data);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL mid_async level=%0d empty=%b full=%b ovf=%b start=%b data=%h want 0/1/0/0/0/00",
               level, empty, full, overflow, tx_start, tx_data);
    end
    step();
    rst = 1'b0;
    got.delete();
    wr_valid = 1'b1;
    wr_data = 8'h3C;
    step();
    wr_valid = 1'b0;
    wait_launches(1, 300);
    repeat (20) step();
    checks++;
    if (got.size() != 1 || got[0] !== 8'h3C) begin
      failures++;
      $display("FAIL mid_next launches=%0d first=%h want 1/3c", got.size(), got.size() > 0 ? got[0] : 8'h00);
    end
    checks++;
    if (busy_viol != 0) begin
      failures++;
      $display("FAIL mid_busy launches_while_busy=%0d want 0", busy_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
